// File: rtl/chunked_adder.sv
// chunked_adder: multi-cycle two's-complement adder/subtractor.
// Sums a WIDTH-bit operand pair CHUNK bits per clock through a ripple chain
// of full-adder cells, carrying between chunks in a register.
//
// Ports:
//   clock, reset_n       clock and asynchronous active-low reset
//   start, sub, a, b     request, mode (0 add / 1 subtract) and operands,
//                        sampled when the block is not busy
//   busy                 high while the operation is in RUN
//   done                 one-cycle pulse, results valid in that cycle
//   sum                  WIDTH-bit result, held until the next completion
//   carry_out            carry out of the MSB (subtract: 1 = no borrow)
//   overflow             signed overflow of the WIDTH-bit result
module chunked_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int unsigned STEPS = WIDTH / CHUNK;
    localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic             carry_r;
    logic [CNT_W-1:0] cnt;

    logic             load;
    logic             step;
    logic             last;

    logic [CHUNK:0]   chain_c;
    logic [CHUNK-1:0] chain_s;
    logic [WIDTH-1:0] sum_shift;

    // Ripple chain over the low chunk of the operand shift registers.
    always_comb begin
        chain_c    = '0;
        chain_s    = '0;
        chain_c[0] = carry_r;
        for (int i = 0; i < int'(CHUNK); i++) begin
            chain_s[i]   = a_sh[i] ^ b_sh[i] ^ chain_c[i];
            chain_c[i+1] = (a_sh[i] & b_sh[i]) | (chain_c[i] & (a_sh[i] ^ b_sh[i]));
        end
    end

    // New chunk enters at the top; after STEPS shifts the word is aligned.
    // The concat form stays legal when CHUNK == WIDTH.
    assign sum_shift = WIDTH'({chain_s, sum_sh} >> CHUNK);
    assign last      = (cnt == CNT_W'(STEPS - 1));

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand/carry/sum shift registers and the visible result registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a_sh      <= '0;
            b_sh      <= '0;
            sum_sh    <= '0;
            carry_r   <= 1'b0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            busy <= (state_next == RUN);
            done <= (state_next == DONE);
            if (load) begin
                // Subtract is a + ~b + 1: the +1 rides in as the initial carry.
                a_sh    <= a;
                b_sh    <= sub ? ~b : b;
                carry_r <= sub;
                cnt     <= '0;
            end else if (step) begin
                a_sh    <= a_sh >> CHUNK;
                b_sh    <= b_sh >> CHUNK;
                sum_sh  <= sum_shift;
                carry_r <= chain_c[CHUNK];
                cnt     <= cnt + CNT_W'(1);
                if (last) begin
                    sum       <= sum_shift;
                    carry_out <= chain_c[CHUNK];
                    overflow  <= chain_c[CHUNK] ^ chain_c[CHUNK-1];
                end
            end
        end
    end

endmodule

// File: tb/tb_chunked_adder.sv
// tb_chunked_adder: directed self-checking bench for chunked_adder
// (WIDTH=16, CHUNK=4) plus a reference-model sweep over WIDTH/CHUNK pairs.
module tb_chunked_adder;

    localparam int unsigned WIDTH    = 16;
    localparam int unsigned CHUNK    = 4;
    localparam int unsigned STEPS    = WIDTH / CHUNK;
    localparam int          MAX_WAIT = 60;
    localparam int unsigned NCFG     = 8;
    localparam int unsigned SW_W [NCFG] = '{8, 8, 16, 16, 16, 32, 32, 32};
    localparam int unsigned SW_C [NCFG] = '{1, 4, 1, 4, 16, 1, 4, 16};
    localparam int          SW_OPS   = 300;

    logic             clock = 1'b0;
    logic             reset_n;
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;

    logic [NCFG-1:0]  sw_start;
    logic [NCFG-1:0]  sw_sub;
    logic [31:0]      sw_a [NCFG];
    logic [31:0]      sw_b [NCFG];
    logic [NCFG-1:0]  sw_busy;
    logic [NCFG-1:0]  sw_done;
    logic [31:0]      sw_sum [NCFG];
    logic [NCFG-1:0]  sw_cout;
    logic [NCFG-1:0]  sw_ovf;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    chunked_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) u_dut (
        .clock(clock), .reset_n(reset_n), .start(start), .sub(sub),
        .a(a), .b(b), .busy(busy), .done(done), .sum(sum),
        .carry_out(carry_out), .overflow(overflow)
    );

    for (genvar g = 0; g < int'(NCFG); g++) begin : g_sw
        localparam int unsigned W = SW_W[g];
        localparam int unsigned C = SW_C[g];
        logic [W-1:0] s_sum;
        chunked_adder #(.WIDTH(W), .CHUNK(C)) u_sw (
            .clock(clock), .reset_n(reset_n), .start(sw_start[g]), .sub(sw_sub[g]),
            .a(sw_a[g][W-1:0]), .b(sw_b[g][W-1:0]), .busy(sw_busy[g]),
            .done(sw_done[g]), .sum(s_sum), .carry_out(sw_cout[g]),
            .overflow(sw_ovf[g])
        );
        assign sw_sum[g] = 32'(s_sum);
    end

    // Issue one operation on the main DUT and wait (bounded) for done.
    // lat counts rising edges from the accepting edge to done visibility.
    task automatic run_op(input logic [15:0] ai, input logic [15:0] bi, input logic si,
                          output int lat, output int busy_cycles);
        @(negedge clock);
        a = ai; b = bi; sub = si; start = 1'b1;
        @(posedge clock);
        lat = 1;
        busy_cycles = 0;
        @(negedge clock);
        start = 1'b0;
        while (!done && lat < MAX_WAIT) begin
            if (busy) busy_cycles++;
            @(posedge clock);
            lat++;
            @(negedge clock);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b exp 0", done); end
        checks++; if (sum !== 16'h0000) begin errors++; $display("FAIL reset_sum got %h exp 0000", sum); end
        checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL reset_cout got %0b exp 0", carry_out); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0b exp 0", overflow); end
    endtask

    task automatic test_basic();
        int lat, bc;
        run_op(16'h1234, 16'h4321, 1'b0, lat, bc);
        checks++; if (lat !== int'(STEPS + 1)) begin errors++; $display("FAIL basic_latency got %0d exp %0d", lat, STEPS + 1); end
        checks++; if (bc !== int'(STEPS)) begin errors++; $display("FAIL basic_busy_cycles got %0d exp %0d", bc, STEPS); end
        checks++; if (sum !== 16'h5555) begin errors++; $display("FAIL basic_sum got %h exp 5555", sum); end
        checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL basic_cout got %0b exp 0", carry_out); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL basic_ovf got %0b exp 0", overflow); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_in_done got %0b exp 0", busy); end
        @(negedge clock);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %0b exp 0", done); end
    endtask

    task automatic test_carry();
        int lat, bc;
        run_op(16'hFFFF, 16'h0001, 1'b0, lat, bc);
        checks++; if (sum !== 16'h0000) begin errors++; $display("FAIL wrap_sum got %h exp 0000", sum); end
        checks++; if (carry_out !== 1'b1) begin errors++; $display("FAIL wrap_cout got %0b exp 1", carry_out); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL wrap_ovf got %0b exp 0", overflow); end
        run_op(16'h7FFF, 16'h0001, 1'b0, lat, bc);
        checks++; if (sum !== 16'h8000) begin errors++; $display("FAIL posovf_sum got %h exp 8000", sum); end
        checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL posovf_cout got %0b exp 0", carry_out); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL posovf_ovf got %0b exp 1", overflow); end
    endtask

    task automatic test_subtract();
        int lat, bc;
        run_op(16'h0005, 16'h0007, 1'b1, lat, bc);
        checks++; if (sum !== 16'hFFFE) begin errors++; $display("FAIL sub_small_sum got %h exp fffe", sum); end
        checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL sub_small_cout got %0b exp 0", carry_out); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL sub_small_ovf got %0b exp 0", overflow); end
        run_op(16'h8000, 16'h0001, 1'b1, lat, bc);
        checks++; if (sum !== 16'h7FFF) begin errors++; $display("FAIL sub_ovf_sum got %h exp 7fff", sum); end
        checks++; if (carry_out !== 1'b1) begin errors++; $display("FAIL sub_ovf_cout got %0b exp 1", carry_out); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL sub_ovf_ovf got %0b exp 1", overflow); end
    endtask

    // Previous result is 0x7FFF; a start pulse mid-RUN must be ignored.
    task automatic test_hold_ignore();
        int ndone = 0;
        logic [15:0] got = '0;
        @(negedge clock);
        a = 16'h1111; b = 16'h2222; sub = 1'b0; start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL hold_busy got %0b exp 1", busy); end
        checks++; if (sum !== 16'h7FFF) begin errors++; $display("FAIL hold_sum_early got %h exp 7fff", sum); end
        @(posedge clock);
        @(negedge clock);
        a = 16'hAAAA; b = 16'h5555; sub = 1'b1; start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        checks++; if (sum !== 16'h7FFF) begin errors++; $display("FAIL hold_sum_late got %h exp 7fff", sum); end
        for (int i = 0; i < 12; i++) begin
            @(posedge clock);
            @(negedge clock);
            if (done) begin ndone++; got = sum; end
        end
        checks++; if (ndone !== 1) begin errors++; $display("FAIL ignore_done_count got %0d exp 1", ndone); end
        checks++; if (got !== 16'h3333) begin errors++; $display("FAIL ignore_sum got %h exp 3333", got); end
    endtask

    task automatic test_back_to_back();
        int t[$];
        int both = 0;
        int bad_sum = 0;
        int guard = 0;
        @(negedge clock);
        a = 16'h0100; b = 16'h0023; sub = 1'b0; start = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(posedge clock);
            @(negedge clock);
            if (busy && done) both++;
            if (done) begin
                t.push_back(cyc);
                if (sum !== 16'h0123) bad_sum++;
            end
        end
        start = 1'b0;
        while ((busy || done) && guard < MAX_WAIT) begin
            @(posedge clock);
            @(negedge clock);
            guard++;
        end
        checks++; if (t.size() !== 4) begin errors++; $display("FAIL b2b_done_count got %0d exp 4", t.size()); end
        checks++; if (bad_sum !== 0) begin errors++; $display("FAIL b2b_sum got %0d wrong results exp 0", bad_sum); end
        checks++; if (both !== 0) begin errors++; $display("FAIL b2b_busy_and_done got %0d cycles exp 0", both); end
        if (t.size() == 4) begin
            checks++; if (t[0] !== int'(STEPS)) begin errors++; $display("FAIL b2b_first got cycle %0d exp %0d", t[0], STEPS); end
            checks++; if (t[1] - t[0] !== 5) begin errors++; $display("FAIL b2b_interval1 got %0d exp 5", t[1] - t[0]); end
            checks++; if (t[3] - t[2] !== 5) begin errors++; $display("FAIL b2b_interval3 got %0d exp 5", t[3] - t[2]); end
        end
        checks++; if (guard >= MAX_WAIT) begin errors++; $display("FAIL b2b_drain got timeout exp idle"); end
    endtask

    task automatic test_reset_mid();
        int lat, bc;
        int spurious = 0;
        @(negedge clock);
        a = 16'h1111; b = 16'h1111; sub = 1'b0; start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %0b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done got %0b exp 0", done); end
        checks++; if (sum !== 16'h0000) begin errors++; $display("FAIL abort_sum got %h exp 0000", sum); end
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (done || busy) spurious++;
        end
        checks++; if (spurious !== 0) begin errors++; $display("FAIL abort_no_done got %0d active cycles exp 0", spurious); end
        run_op(16'h0001, 16'h0001, 1'b0, lat, bc);
        checks++; if (lat !== int'(STEPS + 1)) begin errors++; $display("FAIL after_reset_latency got %0d exp %0d", lat, STEPS + 1); end
        checks++; if (sum !== 16'h0002) begin errors++; $display("FAIL after_reset_sum got %h exp 0002", sum); end
    endtask

    task automatic test_sweep();
        for (int k = 0; k < int'(NCFG); k++) begin
            int unsigned w = SW_W[k];
            int unsigned steps = SW_W[k] / SW_C[k];
            logic [63:0] mask = (64'd1 << w) - 64'd1;
            for (int n = 0; n < SW_OPS; n++) begin
                logic [63:0] ra, rb, bb, full, es;
                logic rs, ec, eo;
                int lat;
                ra = 64'($urandom) & mask;
                rb = 64'($urandom) & mask;
                rs = 1'($urandom_range(0, 1));
                if (n == 0) begin ra = mask; rb = 64'd1; rs = 1'b0; end
                if (n == 1) begin ra = mask >> 1; rb = 64'd1; rs = 1'b0; end
                if (n == 2) begin ra = 64'd1 << (w - 1); rb = 64'd1; rs = 1'b1; end
                bb   = (rs ? ~rb : rb) & mask;
                full = ra + bb + 64'(rs);
                es   = full & mask;
                ec   = full[w];
                eo   = (ra[w-1] == bb[w-1]) && (es[w-1] != ra[w-1]);
                @(negedge clock);
                sw_a[k] = 32'(ra); sw_b[k] = 32'(rb); sw_sub[k] = rs; sw_start[k] = 1'b1;
                @(posedge clock);
                lat = 1;
                @(negedge clock);
                sw_start[k] = 1'b0;
                while (!sw_done[k] && lat < MAX_WAIT) begin
                    @(posedge clock);
                    lat++;
                    @(negedge clock);
                end
                checks++; if (lat !== int'(steps + 1)) begin errors++; $display("FAIL sweep_latency cfg %0d got %0d exp %0d", k, lat, steps + 1); end
                checks++; if (sw_sum[k] !== 32'(es)) begin errors++; $display("FAIL sweep_sum cfg %0d a=%h b=%h sub=%0b got %h exp %h", k, ra, rb, rs, sw_sum[k], 32'(es)); end
                checks++; if (sw_cout[k] !== ec) begin errors++; $display("FAIL sweep_cout cfg %0d a=%h b=%h sub=%0b got %0b exp %0b", k, ra, rb, rs, sw_cout[k], ec); end
                checks++; if (sw_ovf[k] !== eo) begin errors++; $display("FAIL sweep_ovf cfg %0d a=%h b=%h sub=%0b got %0b exp %0b", k, ra, rb, rs, sw_ovf[k], eo); end
                checks++; if (sw_busy[k] !== 1'b0) begin errors++; $display("FAIL sweep_busy_in_done cfg %0d got %0b exp 0", k, sw_busy[k]); end
            end
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        start    = 1'b0;
        sub      = 1'b0;
        a        = '0;
        b        = '0;
        sw_start = '0;
        sw_sub   = '0;
        for (int k = 0; k < int'(NCFG); k++) begin
            sw_a[k] = '0;
            sw_b[k] = '0;
        end
        test_reset();
        test_basic();
        test_carry();
        test_subtract();
        test_hold_ignore();
        test_back_to_back();
        test_reset_mid();
        test_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
